// File: rtl/instr_stepper_if.sv
// instr_stepper_if: loader/control inputs and CPU-side issue outputs of the sequencer
interface instr_stepper_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W:0]   prog_len;
   logic              start;
   logic              abort;
   logic              step_mode;
   logic              step;
   logic              loop;
   logic [DATA_W-1:0] instr_out;
   logic              instr_valid;
   logic              is_bubble;
   logic [ADDR_W-1:0] pc_out;
   logic              busy;
   logic              done;

   modport master (
      output wr_en, wr_addr, wr_data, prog_len, start, abort, step_mode, step, loop,
      input  instr_out, instr_valid, is_bubble, pc_out, busy, done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, prog_len, start, abort, step_mode, step, loop,
      output instr_out, instr_valid, is_bubble, pc_out, busy, done
   );
endinterface

// File: rtl/instr_stepper.sv
// instr_stepper: replays a loaded program into the CPU, padding each word with NOP bubbles
module instr_stepper #(
   parameter int                DATA_W    = 16,
   parameter int                DEPTH     = 16,
   parameter int                ADDR_W    = 4,
   parameter logic [DATA_W-1:0] NOP_WORD  = 16'h0800,
   parameter int                NOP_SLOTS = 2
) (
   input logic           clk,
   input logic           rst,
   instr_stepper_if.slave bus
);
   typedef enum logic [2:0] {IDLE, ISSUE, BUBBLE, HOLD, DONE} state_t;

   localparam logic [ADDR_W:0]   DEP   = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0]   ONE   = 1;
   localparam logic [ADDR_W-1:0] PC1   = 1;
   localparam logic [2:0]        BLOAD = 3'(NOP_SLOTS - 1);
   localparam bit                HAS_B = NOP_SLOTS != 0;

   state_t            state, nstate;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] pc, npc;
   logic [ADDR_W:0]   len, clen;
   logic [2:0]        bcnt;
   logic              smode, idle, start_ok, last, more, slot_end;

   assign bus.pc_out = pc;

   // next state: abort first, then start, then the issue/bubble/hold sequencing
   always_comb begin
      idle     = state == IDLE || state == DONE;
      start_ok = idle && bus.start;
      clen     = bus.prog_len > DEP ? DEP : bus.prog_len;
      last     = {1'b0, pc} + ONE == len;
      more     = !last || bus.loop;
      npc      = start_ok || last ? '0 : pc + PC1;
      slot_end = (state == ISSUE && !HAS_B) || (state == BUBBLE && bcnt == 3'd0);
      nstate   = bus.abort                      ? IDLE :
                 start_ok                       ? (clen == '0 ? DONE : ISSUE) :
                 (state == ISSUE && HAS_B)      ? BUBBLE :
                 slot_end                       ? (!more ? DONE : smode ? HOLD : ISSUE) :
                 (state == HOLD && bus.step)    ? ISSUE : state;
   end

   // program store write port, only while not sequencing
   always_ff @(posedge clk) begin
      if (rst && !bus.abort && bus.wr_en && idle) mem[bus.wr_addr] <= bus.wr_data;
   end

   // state and registered outputs, all derived from the next state
   always_ff @(posedge clk) begin
      if (!rst) begin
         state           <= IDLE;
         bus.instr_out   <= NOP_WORD;
         bus.instr_valid <= 1'b0;
         bus.is_bubble   <= 1'b0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         pc              <= '0;
         len             <= '0;
         smode           <= 1'b0;
         bcnt            <= '0;
      end else begin
         state           <= nstate;
         bus.instr_out   <= nstate == ISSUE ? mem[npc] : NOP_WORD;
         bus.instr_valid <= nstate == ISSUE || nstate == BUBBLE;
         bus.is_bubble   <= nstate == BUBBLE;
         bus.busy        <= nstate == ISSUE || nstate == BUBBLE || nstate == HOLD;
         bus.done        <= nstate == DONE;
         if (nstate == ISSUE) pc <= npc;
         if (start_ok && !bus.abort) begin
            len   <= clen;
            smode <= bus.step_mode;
         end
         if (nstate == BUBBLE) bcnt <= state == ISSUE ? BLOAD : bcnt - 3'd1;
      end
   end
endmodule
